// File: rtl/scan_pkg.sv
// Shared definitions for the channel scan sequencer.
// The BLANK state is only present when SCAN_SEQ_BLANK_EN is defined.
package scan_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1
`ifdef SCAN_SEQ_BLANK_EN
    ,
    BLANK = 2'd2
`endif
  } scan_state_e;

endpackage

// File: rtl/scan_sequencer_next_set_bit.sv
// Finds the next enabled channel strictly above the current index,
// falling back to the lowest enabled channel (a wrap) when none is above.
module next_set_bit
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur_idx,
  output logic [SEL_W-1:0]  next_idx,
  output logic              wrapped,
  output logic              none_set
);

  logic             above_found;
  logic [SEL_W-1:0] above_idx;
  logic [SEL_W-1:0] low_idx;

  // Scan from the top down so the last hit is the lowest qualifying bit
  always_comb begin
    above_found = 1'b0;
    above_idx   = '0;
    low_idx     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_idx = SEL_W'(i);
        if (i > int'(cur_idx)) begin
          above_found = 1'b1;
          above_idx   = SEL_W'(i);
        end
      end
    end
    none_set = (mask == '0);
    wrapped  = !above_found;
    next_idx = above_found ? above_idx : low_idx;
  end

endmodule

// File: rtl/scan_sequencer.sv
// Channel scan sequencer: walks the set bits of mask, holding each channel
// for max(dwell,1) cycles and pulsing wrap at the start of each new sweep.
// Define SCAN_SEQ_BLANK_EN to insert one blanking cycle between channels.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_CH-1:0]  mask,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_en,
  output logic               wrap,
  output logic               busy
);

  scan_state_e        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
`ifdef SCAN_SEQ_BLANK_EN
  logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
  logic               pend_wrap_q, pend_wrap_d;
`endif

  logic [SEL_W-1:0]   nsb_cur;
  logic [SEL_W-1:0]   nsb_next;
  logic               nsb_wrapped;
  logic               nsb_none;
  logic [DWELL_W-1:0] dwell_load;

  // From IDLE, searching above index 15 always wraps to the lowest set bit
  assign nsb_cur    = (state_q == IDLE) ? '1 : sel_q;
  assign dwell_load = (dwell == '0) ? DWELL_W'(1) : dwell;

  next_set_bit u_next_set_bit (
    .mask     (mask),
    .cur_idx  (nsb_cur),
    .next_idx (nsb_next),
    .wrapped  (nsb_wrapped),
    .none_set (nsb_none)
  );

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      wrap_q      <= 1'b0;
`ifdef SCAN_SEQ_BLANK_EN
      pend_sel_q  <= '0;
      pend_wrap_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
`ifdef SCAN_SEQ_BLANK_EN
      pend_sel_q  <= pend_sel_d;
      pend_wrap_q <= pend_wrap_d;
`endif
    end
  end

  // Next state: stop wins over everything, then start / dwell expiry
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    wrap_d      = 1'b0;
`ifdef SCAN_SEQ_BLANK_EN
    pend_sel_d  = pend_sel_q;
    pend_wrap_d = pend_wrap_q;
`endif
    if (stop) begin
      state_d = IDLE;
      sel_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !nsb_none) begin
            state_d = DWELL;
            sel_d   = nsb_next;
            cnt_d   = dwell_load;
          end
        end
        DWELL: begin
          if (cnt_q > DWELL_W'(1)) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if (nsb_none) begin
            state_d = IDLE;
            sel_d   = '0;
            cnt_d   = '0;
          end else begin
`ifdef SCAN_SEQ_BLANK_EN
            state_d     = BLANK;
            pend_sel_d  = nsb_next;
            pend_wrap_d = nsb_wrapped;
            cnt_d       = '0;
`else
            sel_d  = nsb_next;
            cnt_d  = dwell_load;
            wrap_d = nsb_wrapped;
`endif
          end
        end
`ifdef SCAN_SEQ_BLANK_EN
        BLANK: begin
          state_d = DWELL;
          sel_d   = pend_sel_q;
          cnt_d   = dwell_load;
          wrap_d  = pend_wrap_q;
        end
`endif
        default: begin
          state_d = IDLE;
          sel_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded directly from registered state
  always_comb begin
    sel    = sel_q;
    sel_en = (state_q == DWELL);
    wrap   = wrap_q;
    busy   = (state_q != IDLE);
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed testbench for scan_sequencer with hand-computed expectations.
// Blank-cycle expectations apply when SCAN_SEQ_BLANK_EN is defined.
module tb_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [7:0]  dwell;
  logic [15:0] mask;
  logic [3:0]  sel;
  logic        sel_en;
  logic        wrap;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .dwell  (dwell),
    .mask   (mask),
    .sel    (sel),
    .sel_en (sel_en),
    .wrap   (wrap),
    .busy   (busy)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] es, input logic een,
                          input logic ew, input logic eb);
    checkOutput({tag, ".sel"},    16'(sel),    16'(es));
    checkOutput({tag, ".sel_en"}, 16'(sel_en), 16'(een));
    checkOutput({tag, ".wrap"},   16'(wrap),   16'(ew));
    checkOutput({tag, ".busy"},   16'(busy),   16'(eb));
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic [7:0] d,
                               input logic [15:0] m);
    start = s;
    stop  = p;
    dwell = d;
    mask  = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0, 16'h0000);
    #3;
    checkAll("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    #10;
    rst = 1'b0;
    tick();
    checkAll("post_reset", 4'd0, 1'b0, 1'b0, 1'b0);

    // start with empty mask stays idle
    applyStimulus(1'b1, 1'b0, 8'd2, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkAll("mask0_start", 4'd0, 1'b0, 1'b0, 1'b0);
    end

    // mask cleared mid-dwell returns to idle at the next advance
    applyStimulus(1'b1, 1'b0, 8'd3, 16'hFFFF);
    tick();
    checkAll("mclr_enter", 4'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'd3, 16'h0000);
    tick();
    tick();
    checkAll("mclr_hold", 4'd0, 1'b1, 1'b0, 1'b1);
    tick();
    checkAll("mclr_idle", 4'd0, 1'b0, 1'b0, 1'b0);

    // stop and start together in DWELL
    applyStimulus(1'b1, 1'b0, 8'd5, 16'hFFFF);
    tick();
    tick();
    checkAll("ss_dwell", 4'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'd5, 16'hFFFF);
    tick();
    checkAll("stop_start", 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd5, 16'hFFFF);

    // reset mid-dwell forces outputs low without waiting for a clock
    applyStimulus(1'b1, 1'b0, 8'd8, 16'hFFFF);
    tick();
    start = 1'b0;
    tick();
    checkAll("pre_rst", 4'd0, 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkAll("rst_async", 4'd0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    tick();
    checkAll("rst_stay_idle", 4'd0, 1'b0, 1'b0, 1'b0);

`ifndef SCAN_SEQ_BLANK_EN
    // full sweep, 2 cycles per channel, wrap on return to 0
    applyStimulus(1'b1, 1'b0, 8'd2, 16'hFFFF);
    tick();
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      checkAll("sweep", 4'(k / 2), 1'b1, 1'b0, 1'b1);
      tick();
    end
    checkAll("sweep_wrap", 4'd0, 1'b1, 1'b1, 1'b1);
    tick();
    checkAll("sweep_wrap_once", 4'd0, 1'b1, 1'b0, 1'b1);
    stop = 1'b1;
    tick();
    checkAll("sweep_stop", 4'd0, 1'b0, 1'b0, 1'b0);

    // sparse mask with dwell=0 behaving as 1
    applyStimulus(1'b1, 1'b0, 8'd0, 16'h8421);
    tick();
    start = 1'b0;
    checkAll("sparse0", 4'd0, 1'b1, 1'b0, 1'b1);
    tick();
    checkAll("sparse5", 4'd5, 1'b1, 1'b0, 1'b1);
    tick();
    checkAll("sparse10", 4'd10, 1'b1, 1'b0, 1'b1);
    tick();
    checkAll("sparse15", 4'd15, 1'b1, 1'b0, 1'b1);
    tick();
    checkAll("sparse_wrap", 4'd0, 1'b1, 1'b1, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // start held while scanning is ignored
    applyStimulus(1'b1, 1'b0, 8'd1, 16'hFFFF);
    tick();
    checkAll("hold_start0", 4'd0, 1'b1, 1'b0, 1'b1);
    tick();
    checkAll("hold_start1", 4'd1, 1'b1, 1'b0, 1'b1);
    tick();
    checkAll("hold_start2", 4'd2, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'd1, 16'hFFFF);
    tick();
    stop = 1'b0;

    // dwell changed mid-channel only affects the next channel
    applyStimulus(1'b1, 1'b0, 8'd4, 16'h0003);
    tick();
    checkAll("dchg_enter", 4'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'd1, 16'h0003);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkAll("dchg_hold", 4'd0, 1'b1, 1'b0, 1'b1);
    end
    tick();
    checkAll("dchg_next", 4'd1, 1'b1, 1'b0, 1'b1);
    tick();
    checkAll("dchg_wrap", 4'd0, 1'b1, 1'b1, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
`else
    // one blanking cycle between every channel, wrap after blank
    applyStimulus(1'b1, 1'b0, 8'd1, 16'h0003);
    tick();
    start = 1'b0;
    checkAll("blank_d0", 4'd0, 1'b1, 1'b0, 1'b1);
    tick();
    checkAll("blank_b0", 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkAll("blank_d1", 4'd1, 1'b1, 1'b0, 1'b1);
    tick();
    checkAll("blank_b1", 4'd1, 1'b0, 1'b0, 1'b1);
    tick();
    checkAll("blank_wrap", 4'd0, 1'b1, 1'b1, 1'b1);
    stop = 1'b1;
    tick();
    checkAll("blank_stop", 4'd0, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, giving the width of the dwell-count input.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit: begin scanning, level-sampled each clk edge.
REQ-005 SHALL have port stop, input, 1 bit: abort scanning, level-sampled each clk edge.
REQ-006 SHALL have port dwell, input, DWELL_W bits: number of cycles each channel is held.
REQ-007 SHALL have port mask, input, 16 bits: channel n is visited only if mask[n]=1.
REQ-008 SHALL have port sel, output, 4 bits: channel index for the downstream 4-to-16 decoder input.
REQ-009 SHALL have port sel_en, output, 1 bit: decoder enable; high only while a channel is driven.
REQ-010 SHALL have port wrap, output, 1 bit: one-cycle pulse on completion of a full sweep.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, DWELL, and BLANK (BLANK exists only per REQ-024).
REQ-013 SHALL, in IDLE with start=1, stop=0 and mask!=0, load sel with the lowest set bit of mask and enter DWELL next cycle.
REQ-014 SHALL remain in IDLE, with all outputs low, when start=1 and mask=0.
REQ-015 SHALL drive sel_en=1 in DWELL, and sel_en=0 in IDLE and BLANK.
REQ-016 SHALL load a dwell down-counter on entry to each channel; effective dwell = max(dwell,1) cycles, so dwell=0 behaves as 1.
REQ-017 SHALL sample dwell and mask only at channel-entry and advance time; changes mid-dwell do not affect the current channel.
REQ-018 SHALL, at dwell expiry, advance sel to the next set mask bit strictly above the current index, wrapping from 15 to 0.
REQ-019 SHALL pulse wrap for exactly one cycle, coincident with the first sel_en cycle of the new sweep, when an advance wraps (next index <= current index); a single-bit mask wraps on every advance.
REQ-020 SHALL, when mask=0 at advance time, return to IDLE with sel=0.
REQ-021 SHALL, on stop=1 in any state, enter IDLE on the next edge with sel=0 and sel_en=0; stop takes priority over start and over dwell expiry.
REQ-022 SHALL ignore start outside IDLE.

Reset
REQ-023 SHALL, while rst=1, immediately force state=IDLE, sel=0, sel_en=0, wrap=0, busy=0 and dwell counter=0, including mid-dwell; scanning resumes only on a new start.

Configuration
REQ-024 SHALL, when SCAN_SEQ_BLANK_EN is defined, insert exactly one BLANK cycle (sel_en=0, sel unchanged, busy=1) between every channel advance, including wrap; wrap pulses on the DWELL cycle after BLANK.
REQ-025 SHALL, when SCAN_SEQ_BLANK_EN is undefined, go directly from DWELL to DWELL with no BLANK state compiled in.

Structure
REQ-026 SHALL take the state enum, NUM_CH=16 and SEL_W=4 from shared package scan_pkg.
REQ-027 SHALL compute the next channel in combinational sub-module next_set_bit (inputs mask and current index; outputs next index, wrapped flag and none-set flag).

Verification
REQ-028 SHALL cover: mask=16'hFFFF, dwell=2, start pulse -> sel 0..15 each held 2 cycles with sel_en=1; wrap pulses once when sel returns to 0 (32 cycles after the first sel_en).
REQ-029 SHALL cover: mask=16'h8421, dwell=0 -> sel sequence 0,5,10,15,0 with 1 cycle each; wrap high on the second visit to 0.
REQ-030 SHALL cover: mask=0 with start=1 -> busy=0 and sel_en=0 throughout; mask cleared mid-scan -> IDLE at the next advance.
REQ-031 SHALL cover: stop and start asserted together in DWELL -> IDLE next cycle with sel=0; rst asserted mid-dwell -> all outputs 0 asynchronously.
REQ-032 SHALL cover: SCAN_SEQ_BLANK_EN defined, mask=16'h0003, dwell=1 -> sel_en pattern 1,0,1,0 with sel 0,0,1,1.
REQ-033 SHALL cover: dwell changed from 4 to 1 mid-channel -> current channel holds 4 cycles; the next channel holds 1.
